// File: rtl/wishbone_ram_secondary.sv
// Wishbone secondary backed by a byte-lane-writable RAM. A three-state FSM
// inserts WAIT_STATES wait cycles, then a one-cycle ack.
module wishbone_ram_secondary #(
    parameter int DATA_SIZE   = 32,
    parameter int BYTE_SIZE   = 8,
    parameter int ADDR_SIZE   = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cyc,
    input  logic                           stb,
    input  logic                           we,
    input  logic [ADDR_SIZE-1:0]           addr,
    input  logic [DATA_SIZE/BYTE_SIZE-1:0] sel,
    input  logic [DATA_SIZE-1:0]           dat_i_s,
    output logic [DATA_SIZE-1:0]           dat_o_s,
    output logic                           ack
);
    localparam int LANES     = DATA_SIZE / BYTE_SIZE;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic                  we_q, we_d;
    logic [LANES-1:0]      sel_q, sel_d;
    logic [DATA_SIZE-1:0]  wdat_q, wdat_d;
    logic                  ack_q, ack_d;
    logic [DATA_SIZE-1:0]  dat_o_q, dat_o_d;
    logic [DATA_SIZE-1:0]  mem_q [DEPTH];

    logic                  req_s;
    logic                  mem_wr_s;
    logic [IDX_BITS-1:0]   addr_idx_s;
    logic                  unused_addr_s;

    assign req_s         = cyc & stb;
    assign addr_idx_s    = addr[LANE_BITS +: IDX_BITS];
    assign unused_addr_s = ^addr;

    // Next-state, latch and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        ack_d    = 1'b0;
        dat_o_d  = '0;
        mem_wr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    idx_d  = addr_idx_s;
                    we_d   = we;
                    sel_d  = sel;
                    wdat_d = dat_i_s;
                    cnt_d  = WS_INIT;
                    if (WS_INIT == 4'd0) begin
                        // No wait states: the read word is fetched from the live address
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        if (!we) begin
                            dat_o_d = mem_q[addr_idx_s];
                        end else begin
                            dat_o_d = '0;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        if (!we_q) begin
                            dat_o_d = mem_q[idx_q];
                        end else begin
                            dat_o_d = '0;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_ACK: begin
                state_d  = ST_IDLE;
                mem_wr_s = we_q & ~reset;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
        end
    end

    // Byte-lane RAM write on the edge ending ACK; contents survive reset
    always_ff @(posedge clock) begin
        if (mem_wr_s) begin
            for (int b = 0; b < LANES; b++) begin
                if (sel_q[b]) begin
                    mem_q[idx_q][b*BYTE_SIZE +: BYTE_SIZE] <= wdat_q[b*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    assign ack     = ack_q;
    assign dat_o_s = dat_o_q;

endmodule

// File: tb/tb_wishbone_ram_secondary.sv
// Bench for wishbone_ram_secondary: three instances (WAIT_STATES 1, 0, 3)
// on a shared bus with per-instance cyc, checked against a word/byte array model.
module tb_wishbone_ram_secondary;
    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  cyc;
    logic        stb, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic        ack_w  [3];
    logic [31:0] dout_w [3];

    int vectors = 0;
    int miscompares = 0;
    int ws_of [3] = '{1, 0, 3};
    logic [31:0] mdl   [3][256];
    logic [3:0]  known [3][256];

    always #5 clock = ~clock;

    wishbone_ram_secondary #(.WAIT_STATES(1)) u_ws1 (
        .clock(clock), .reset(reset), .cyc(cyc[0]), .stb(stb), .we(we), .addr(addr),
        .sel(sel), .dat_i_s(dat_i), .dat_o_s(dout_w[0]), .ack(ack_w[0]));
    wishbone_ram_secondary #(.WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .cyc(cyc[1]), .stb(stb), .we(we), .addr(addr),
        .sel(sel), .dat_i_s(dat_i), .dat_o_s(dout_w[1]), .ack(ack_w[1]));
    wishbone_ram_secondary #(.WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(reset), .cyc(cyc[2]), .stb(stb), .we(we), .addr(addr),
        .sel(sel), .dat_i_s(dat_i), .dat_o_s(dout_w[2]), .ack(ack_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd256);
    endfunction

    task automatic model_write(input int inst, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
        int w = word_of(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                mdl[inst][w][8*b +: 8] = d[8*b +: 8];
                known[inst][w][b] = 1'b1;
            end
        end
    endtask

    // One isolated transfer; inputs are scrambled after sampling to prove they were latched
    task automatic xfer(input int inst, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
        int ws = ws_of[inst];
        int wi = word_of(a);
        logic [31:0] exp = mdl[inst][wi];
        logic full = (known[inst][wi] == 4'hF);
        rd = 32'h0;
        @(negedge clock);
        we = w; addr = a; sel = s; dat_i = d; stb = 1'b1; cyc[inst] = 1'b1;
        for (int k = 1; k <= ws + 1; k++) begin
            @(negedge clock);
            if (k == 1) begin
                addr = $urandom; sel = 4'($urandom); dat_i = $urandom; we = 1'($urandom);
            end
            if (k == ws + 1) begin
                chk("ack_on_time", 32'(ack_w[inst]), 32'd1);
                rd = dout_w[inst];
                if (!w && full) chk("read_data", dout_w[inst], exp);
            end else begin
                chk("ack_early", 32'(ack_w[inst]), 32'd0);
                chk("dout_wait", dout_w[inst], 32'd0);
            end
        end
        cyc[inst] = 1'b0; stb = 1'b0;
        if (w) model_write(inst, a, s, d);
        @(negedge clock);
        chk("ack_one_cycle", 32'(ack_w[inst]), 32'd0);
        chk("dout_after", dout_w[inst], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, a, d, prior;
        int idx;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 256; j++) begin
                known[i][j] = 4'h0;
                mdl[i][j] = 32'h0;
            end
        reset = 1'b1; cyc = 3'b000; stb = 1'b0; we = 1'b0;
        addr = 32'h0; sel = 4'h0; dat_i = 32'h0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk("reset_ack", 32'(ack_w[i]), 32'd0);
            chk("reset_dout", dout_w[i], 32'd0);
        end
        reset = 1'b0;

        // Basic write/read with one wait state
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, rd);
        chk("basic_read", rd, 32'hDEADBEEF);

        // Partial lane write
        xfer(0, 1'b1, 32'h8, 4'hF, 32'h11223344, rd);
        xfer(0, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD, rd);
        xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, rd);
        chk("partial_read", rd, 32'h11BB33DD);

        // All-zero sel still acks, memory unchanged
        xfer(0, 1'b1, 32'h8, 4'h0, 32'h55555555, rd);
        xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, rd);
        chk("sel_zero_read", rd, 32'h11BB33DD);

        // Address aliasing modulo DEPTH words
        xfer(0, 1'b1, 32'h000, 4'hF, 32'hCAFEF00D, rd);
        xfer(0, 1'b0, 32'h400, 4'h0, 32'h0, rd);
        chk("alias_read", rd, 32'hCAFEF00D);

        // Preload words 0..15 of every instance with full writes
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 16; j++)
                xfer(i, 1'b1, 32'(j * 4), 4'hF, $urandom, rd);

        // Back-to-back reads with zero wait states
        @(negedge clock);
        we = 1'b0; addr = 32'h0; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if ((k % 2 == 1) && k <= 7) begin
                chk("b2b_ack_hi", 32'(ack_w[1]), 32'd1);
                chk("b2b_data", dout_w[1], mdl[1][(k - 1) / 2]);
                addr = 32'(((k + 1) / 2) * 4);
            end else begin
                chk("b2b_ack_lo", 32'(ack_w[1]), 32'd0);
                chk("b2b_dout_zero", dout_w[1], 32'd0);
            end
            if (k == 7) begin
                cyc[1] = 1'b0; stb = 1'b0;
            end
        end

        // Read immediately following a write to the same word
        d = $urandom;
        @(negedge clock);
        we = 1'b1; addr = 32'h20; sel = 4'hF; dat_i = d; stb = 1'b1; cyc[1] = 1'b1;
        @(negedge clock);
        chk("raw_wr_ack", 32'(ack_w[1]), 32'd1);
        we = 1'b0;
        @(negedge clock);
        chk("raw_gap", 32'(ack_w[1]), 32'd0);
        @(negedge clock);
        chk("raw_rd_ack", 32'(ack_w[1]), 32'd1);
        chk("raw_data", dout_w[1], d);
        cyc[1] = 1'b0; stb = 1'b0;
        model_write(1, 32'h20, 4'hF, d);
        @(negedge clock);
        chk("raw_end", 32'(ack_w[1]), 32'd0);

        // cyc dropped in the second wait cycle aborts the write
        prior = mdl[2][1];
        @(negedge clock);
        we = 1'b1; addr = 32'h4; sel = 4'hF; dat_i = ~prior; stb = 1'b1; cyc[2] = 1'b1;
        @(negedge clock);
        chk("abort_w1", 32'(ack_w[2]), 32'd0);
        @(negedge clock);
        cyc[2] = 1'b0; stb = 1'b0;
        chk("abort_w2", 32'(ack_w[2]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("abort_no_ack", 32'(ack_w[2]), 32'd0);
        end
        xfer(2, 1'b0, 32'h4, 4'hF, 32'h0, rd);
        chk("abort_prior", rd, prior);

        // Reset during a wait cycle, then a read sampled on the first free edge
        prior = mdl[0][12];
        @(negedge clock);
        we = 1'b1; addr = 32'h30; sel = 4'hF; dat_i = ~prior; stb = 1'b1; cyc[0] = 1'b1;
        @(negedge clock);
        reset = 1'b1; we = 1'b0;
        @(negedge clock);
        chk("rst_ack", 32'(ack_w[0]), 32'd0);
        chk("rst_dout", dout_w[0], 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_next_wait", 32'(ack_w[0]), 32'd0);
        @(negedge clock);
        chk("rst_next_ack", 32'(ack_w[0]), 32'd1);
        chk("rst_mem_kept", dout_w[0], prior);
        cyc[0] = 1'b0; stb = 1'b0;
        @(negedge clock);
        chk("rst_next_end", 32'(ack_w[0]), 32'd0);

        // Randomized transfers with aliased upper/lower address bits
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 15);
            a = ($urandom & 32'hFFFF_FC03) | 32'(idx * 4);
            xfer(n % 3, 1'($urandom), a, 4'($urandom), $urandom, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wishbone_ram_secondary.md
WISHBONE_RAM_SECONDARY -- requirements
Module: wishbone_ram_secondary

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, data bus width in bits.
REQ-002 The block SHALL have parameter BYTE_SIZE, default 8, bits per byte lane; DATA_SIZE/BYTE_SIZE lanes.
REQ-003 The block SHALL have parameter ADDR_SIZE, default 32, byte-address width.
REQ-004 The block SHALL have parameter DEPTH, default 256, number of DATA_SIZE words, power of two.
REQ-005 The block SHALL have parameter WAIT_STATES, default 1, range 0..15, extra cycles before ack.
REQ-006 The block SHALL have these ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- cyc  input  1  bus cycle valid.
- stb  input  1  transfer strobe.
- we  input  1  1 = write, 0 = read.
- addr  input  ADDR_SIZE  byte address.
- sel  input  DATA_SIZE/BYTE_SIZE  byte-lane enables.
- dat_i_s  input  DATA_SIZE  write data from primary.
- dat_o_s  output  DATA_SIZE  read data to primary.
- ack  output  1  transfer-complete pulse.

Function
REQ-007 The block SHALL define a request as cyc & stb; read request = request & ~we; write request = request & we.
REQ-008 The block SHALL implement FSM states IDLE, WAIT, ACK.
REQ-009 In IDLE, a sampled request SHALL latch addr, we, sel, dat_i_s and load the wait counter with WAIT_STATES; next state is WAIT if WAIT_STATES>0, else ACK.
REQ-010 In WAIT, the counter SHALL decrement each cycle; the state moves to ACK in the cycle after the counter reaches 1.
REQ-011 ack SHALL be 1 only in ACK, for exactly one cycle, WAIT_STATES+1 cycles after the IDLE sampling edge.
REQ-012 From ACK the FSM SHALL always return to IDLE; a request still present is sampled there as a new transfer, so back-to-back transfers take WAIT_STATES+2 cycles each.
REQ-013 Word index SHALL be addr[log2(DATA_SIZE/BYTE_SIZE) +: log2(DEPTH)]; higher and lower addr bits SHALL be ignored, so addresses alias modulo DEPTH words.
REQ-014 A write SHALL commit only the lanes with the latched sel bit set, on the clock edge ending the ACK cycle; other lanes keep their values.
REQ-015 For a read, dat_o_s SHALL carry the full word at the latched index during the ACK cycle, regardless of sel.
REQ-016 dat_o_s SHALL be 0 whenever ack is 0.
REQ-017 If cyc is 0 in any WAIT cycle, the transfer SHALL abort: go to IDLE next cycle, no ack, no memory write.
REQ-018 Input changes to addr, we, sel, dat_i_s after the IDLE sampling edge SHALL NOT affect the transfer in progress.
REQ-019 A read of a word written by the immediately preceding transfer SHALL return the new data.
REQ-020 A write with sel all zero SHALL still produce ack and leave memory unchanged.

Reset
REQ-021 While reset is 1 at a clock edge, the FSM SHALL go to IDLE, ack SHALL be 0, dat_o_s SHALL be 0 and the wait counter SHALL be 0.
REQ-022 Reset during WAIT or ACK SHALL abort the transfer with no memory write and no ack.
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 The first request SHALL be sampled at the first edge where reset is 0.

Verification
REQ-025 WAIT_STATES=1: write addr 0x10, sel 4'b1111, data 0xDEADBEEF, then read addr 0x10 -> ack 2 cycles after each sampling edge; read returns 0xDEADBEEF.
REQ-026 Partial write: word 0x11223344 at addr 0x8, then write sel 4'b0101, data 0xAABBCCDD -> subsequent read returns 0x11BB33DD.
REQ-027 WAIT_STATES=0, stb held high for 4 back-to-back reads -> ack pulses every 2nd cycle, never 2 consecutive cycles high; dat_o_s = 0 between pulses.
REQ-028 WAIT_STATES=3: drop cyc in the 2nd WAIT cycle of a write to addr 0x4 -> no ack; a later read of 0x4 returns the prior value.
REQ-029 DEPTH=256: write 0xCAFEF00D at addr 0x000 -> a read at addr 0x400 returns 0xCAFEF00D (aliasing).
REQ-030 Assert reset for 1 cycle in WAIT of a write -> ack stays 0, dat_o_s = 0, memory unchanged, the next request completes normally.
